biquad8_power_detect: RTL



---
 rtl/biquad8_pkg.sv | 17 +
 rtl/biquad8_sumsq.sv | 81 ++++++++
 rtl/biquad8_power_detect.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/biquad8_pkg.sv
// Shared types and helpers for the biquad8 power detector.
// No logic; constant functions and the window FSM state type only.
// Not applicable (no datapath).
package biquad8_pkg;

    // Window FSM: waiting for a first tagged sum, or inside an open window.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Lossless width of the per-clock sum of NSAMP signed squares.
    function automatic int sumsq_bits(input int nbits, input int nsamp);
        return 2 * nbits - 1 + $clog2(nsamp);
    endfunction

endpackage

// File: rtl/biquad8_sumsq.sv
// Per-clock sum of squares and lane peak |x| over NSAMP parallel samples, with valid tag.
// Latency 2 clocks (stage 1: square/abs, stage 2: lane sum/max).
// No backpressure; accepts one beat per clock, tag follows the data.
module biquad8_sumsq
    import biquad8_pkg::*;
#(
    parameter int NBITS   = 16,
    parameter int NSAMP   = 8,
    parameter int SUMBITS = sumsq_bits(NBITS, NSAMP)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     tag_i,
    input  logic [NBITS*NSAMP-1:0]   dat_i,
    output logic                     tag_o,
    output logic [SUMBITS-1:0]       sum_o,
    output logic [NBITS-1:0]         max_o
);

    // A square of an NBITS signed value needs one bit less than the full product.
    localparam int SQBITS = 2 * NBITS - 1;

    logic [NSAMP-1:0][2*NBITS-1:0] lane_ext;
    logic [NSAMP-1:0][SQBITS-1:0]  sq_d;
    logic [NSAMP-1:0][SQBITS-1:0]  sq_q;
    logic [NSAMP-1:0][NBITS-1:0]   abs_d;
    logic [NSAMP-1:0][NBITS-1:0]   abs_q;
    logic                          tag1_q;
    logic [SUMBITS-1:0]            sum_d;
    logic [NBITS-1:0]              max_d;

    // Stage-1 combinational: sign-extend each lane, square it, take its magnitude.
    always_comb begin
        for (int k = 0; k < NSAMP; k++) begin
            lane_ext[k] = {{NBITS{dat_i[k*NBITS+NBITS-1]}}, dat_i[k*NBITS +: NBITS]};
            sq_d[k]     = SQBITS'($signed(lane_ext[k]) * $signed(lane_ext[k]));
            // Unsigned magnitude; -2^(NBITS-1) maps to 2^(NBITS-1), which still fits.
            abs_d[k]    = dat_i[k*NBITS+NBITS-1] ? (~dat_i[k*NBITS +: NBITS] + NBITS'(1))
                                                 : dat_i[k*NBITS +: NBITS];
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_q   <= '0;
            abs_q  <= '0;
            tag1_q <= 1'b0;
        end else begin
            sq_q   <= sq_d;
            abs_q  <= abs_d;
            tag1_q <= tag_i;
        end
    end

    // Stage-2 combinational: full-width lane sum and lane maximum.
    always_comb begin
        sum_d = '0;
        max_d = '0;
        for (int k = 0; k < NSAMP; k++) begin
            sum_d = sum_d + SUMBITS'(sq_q[k]);
            if (abs_q[k] > max_d) begin
                max_d = abs_q[k];
            end
        end
    end

    // Stage-2 registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_o <= '0;
            max_o <= '0;
            tag_o <= 1'b0;
        end else begin
            sum_o <= sum_d;
            max_o <= max_d;
            tag_o <= tag1_q;
        end
    end

endmodule

// File: rtl/biquad8_power_detect.sv
// Windowed sum of squares and peak |x| of the filter output; one strobed result per window.
// Latency 3 clocks from the last window sample on dat_i to pow_valid_o.
// No backpressure; dropping en_i aborts the open window without a result.
module biquad8_power_detect
    import biquad8_pkg::*;
#(
    parameter int NBITS   = 16,
    parameter int NSAMP   = 8,
    parameter int ACCBITS = 48,
    parameter int CNTBITS = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [CNTBITS-1:0]       win_len_i,
    input  logic [NBITS*NSAMP-1:0]   dat_i,
    output logic [ACCBITS-1:0]       pow_o,
    output logic                     pow_valid_o,
    output logic                     pow_ovf_o,
    output logic [NBITS-1:0]         peak_o
);

    localparam int SUMBITS = sumsq_bits(NBITS, NSAMP);

    logic                 s2_tag;
    logic [SUMBITS-1:0]   s2_sum;
    logic [NBITS-1:0]     s2_max;

    // win_len_i delayed to line up with the stage-2 sum of the same clock,
    // so the latched length is the one present with the window's first sample.
    logic [CNTBITS-1:0]   len_s1;
    logic [CNTBITS-1:0]   len_s2;

    state_t               state_q, state_d;
    logic [ACCBITS-1:0]   acc_q, acc_d;
    logic [NBITS-1:0]     peak_q, peak_d;
    logic                 ovf_q, ovf_d;
    logic [CNTBITS-1:0]   cnt_q, cnt_d;
    logic [CNTBITS-1:0]   len_q, len_d;

    logic [ACCBITS:0]     add_full;
    logic [ACCBITS-1:0]   acc_sat;
    logic [ACCBITS-1:0]   acc_load;
    logic [NBITS-1:0]     peak_max;
    logic [CNTBITS-1:0]   cnt_inc;

    logic                 done;
    logic [ACCBITS-1:0]   res_pow;
    logic [NBITS-1:0]     res_peak;
    logic                 res_ovf;

    biquad8_sumsq #(
        .NBITS   (NBITS),
        .NSAMP   (NSAMP),
        .SUMBITS (SUMBITS)
    ) u_sumsq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tag_i   (en_i),
        .dat_i   (dat_i),
        .tag_o   (s2_tag),
        .sum_o   (s2_sum),
        .max_o   (s2_max)
    );

    // Window length follows the sample pipeline by two clocks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_s1 <= '0;
            len_s2 <= '0;
        end else begin
            len_s1 <= win_len_i;
            len_s2 <= len_s1;
        end
    end

    // Saturating accumulate, running peak and window counter helpers.
    always_comb begin
        add_full = {1'b0, acc_q} + (ACCBITS+1)'(s2_sum);
        acc_sat  = add_full[ACCBITS] ? {ACCBITS{1'b1}} : add_full[ACCBITS-1:0];
        acc_load = ACCBITS'(s2_sum);
        peak_max = (s2_max > peak_q) ? s2_max : peak_q;
        cnt_inc  = cnt_q + CNTBITS'(1);
    end

    // Window FSM next state, accumulator update and completion decode.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        peak_d   = peak_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        done     = 1'b0;
        res_pow  = acc_sat;
        res_peak = peak_max;
        res_ovf  = ovf_q | add_full[ACCBITS];
        case (state_q)
            IDLE: begin
                if (s2_tag) begin
                    len_d  = len_s2;
                    acc_d  = acc_load;
                    peak_d = s2_max;
                    ovf_d  = 1'b0;
                    cnt_d  = '0;
                    if (len_s2 == '0) begin
                        // Single-clock window: result is this sum alone.
                        done     = 1'b1;
                        res_pow  = acc_load;
                        res_peak = s2_max;
                        res_ovf  = 1'b0;
                        acc_d    = '0;
                        peak_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!s2_tag) begin
                    // Enable dropped: abandon the partial window silently.
                    state_d = IDLE;
                    acc_d   = '0;
                    peak_d  = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_inc == len_q) begin
                    // Last sum of the window; the next tagged sum opens a new one.
                    done    = 1'b1;
                    state_d = IDLE;
                    acc_d   = '0;
                    peak_d  = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    acc_d  = acc_sat;
                    peak_d = peak_max;
                    ovf_d  = res_ovf;
                    cnt_d  = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Window FSM and accumulator state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            peak_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            peak_q  <= peak_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Result registers: updated only on window completion, held otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pow_o       <= '0;
            peak_o      <= '0;
            pow_ovf_o   <= 1'b0;
            pow_valid_o <= 1'b0;
        end else begin
            pow_valid_o <= done;
            if (done) begin
                pow_o     <= res_pow;
                peak_o    <= res_peak;
                pow_ovf_o <= res_ovf;
            end
        end
    end

endmodule
